// File: rtl/keccak_absorb_pad.sv
// Keccak sponge absorb front-end: buffers rate lanes, applies multi-rate padding, hands blocks to a permutation core.
// Define KECCAK_PARTIAL_LANE_EN to honour in_nbytes; otherwise every message is lane-aligned.
module keccak_absorb_pad #(
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DSUFFIX    = 8'h06
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   in_data,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [3:0]    in_nbytes,
  output logic          in_ready,
  output logic          perm_start,
  input  logic          perm_done,
  input  logic [1599:0] state_in,
  output logic [1599:0] out_state,
  output logic          msg_done
);

  typedef enum logic [1:0] {ABSORB, PAD, SEND, WAIT} state_t;

  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

  state_t                       state, state_nxt;
  logic [RATE_LANES-1:0][63:0]  lanes, lanes_nxt;
  logic [4:0]                   cnt, cnt_nxt;
  logic                         final_flag, final_nxt;
  logic                         pad_def, pad_def_nxt;
  logic                         done_nxt;
  logic [1599:0]                state_reg, state_reg_nxt;
  logic [3:0]                   nb;
  logic                         accept;

`ifdef KECCAK_PARTIAL_LANE_EN
  assign nb = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;
`else
  logic unused_nbytes;
  assign unused_nbytes = ^in_nbytes;
  assign nb            = 4'd8;
`endif

  assign accept = in_valid && in_ready;

  // Keep bytes [0..n-1] and place the domain suffix at byte n (n < 8).
  function automatic logic [63:0] pad_lane(input logic [63:0] d, input logic [3:0] n);
    logic [5:0]  sh;
    logic [63:0] keep;
    sh   = {n[2:0], 3'b000};
    keep = (64'd1 << sh) - 64'd1;
    return (d & keep) | ({56'd0, DSUFFIX} << sh);
  endfunction

  function automatic logic [1599:0] xor_block(input logic [1599:0] s,
                                              input logic [RATE_LANES-1:0][63:0] b);
    logic [1599:0] r;
    r = s;
    for (int k = 0; k < RATE_LANES; k++)
      r[1599-64*k -: 64] = r[1599-64*k -: 64] ^ b[k];
    return r;
  endfunction

  always_comb begin
    state_nxt     = state;
    lanes_nxt     = lanes;
    cnt_nxt       = cnt;
    final_nxt     = final_flag;
    pad_def_nxt   = pad_def;
    state_reg_nxt = state_reg;
    done_nxt      = 1'b0;
    case (state)
      ABSORB: begin
        if (accept) begin
          if (in_last && (nb < 4'd8)) begin
            lanes_nxt[cnt]            = pad_lane(in_data, nb);
            lanes_nxt[RATE_LANES-1][63] = 1'b1;
            final_nxt                 = 1'b1;
            state_nxt                 = SEND;
          end else begin
            lanes_nxt[cnt] = in_data;
            cnt_nxt        = cnt + 5'd1;
            if (in_last) begin
              // A full final lane that closes the block pushes padding into a fresh block.
              if (cnt == LAST_LANE) begin
                pad_def_nxt = 1'b1;
                state_nxt   = SEND;
              end else begin
                state_nxt = PAD;
              end
            end else if (cnt == LAST_LANE) begin
              state_nxt = SEND;
            end
          end
        end
      end
      PAD: begin
        lanes_nxt[cnt][7:0]         = DSUFFIX;
        lanes_nxt[RATE_LANES-1][63] = 1'b1;
        final_nxt                   = 1'b1;
        state_nxt                   = SEND;
      end
      SEND: state_nxt = WAIT;
      WAIT: begin
        if (perm_done) begin
          lanes_nxt = '0;
          cnt_nxt   = 5'd0;
          if (final_flag) begin
            state_reg_nxt = '0;
            final_nxt     = 1'b0;
            done_nxt      = 1'b1;
            state_nxt     = ABSORB;
          end else begin
            state_reg_nxt = state_in;
            if (pad_def) begin
              pad_def_nxt = 1'b0;
              state_nxt   = PAD;
            end else begin
              state_nxt = ABSORB;
            end
          end
        end
      end
      default: state_nxt = ABSORB;
    endcase
  end

  // Outputs are registered from next-state so the block is presented together with perm_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ABSORB;
      lanes      <= '0;
      cnt        <= 5'd0;
      final_flag <= 1'b0;
      pad_def    <= 1'b0;
      state_reg  <= '0;
      out_state  <= '0;
      perm_start <= 1'b0;
      msg_done   <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      state      <= state_nxt;
      lanes      <= lanes_nxt;
      cnt        <= cnt_nxt;
      final_flag <= final_nxt;
      pad_def    <= pad_def_nxt;
      state_reg  <= state_reg_nxt;
      perm_start <= (state_nxt == SEND);
      msg_done   <= done_nxt;
      in_ready   <= (state_nxt == ABSORB);
      if (state_nxt == SEND)
        out_state <= xor_block(state_reg_nxt, lanes_nxt);
    end
  end

endmodule

// File: tb/tb_keccak_absorb_pad.sv
// Bench for keccak_absorb_pad: byte-level sponge padding model with randomized messages and permutation responses.
module tb_keccak_absorb_pad;
  localparam int R  = 17;
  localparam int RB = 8 * R;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_last;
  logic [3:0]    in_nbytes;
  logic          in_ready;
  logic          perm_start;
  logic          perm_done;
  logic [1599:0] state_in;
  logic [1599:0] out_state;
  logic          msg_done;

  int total  = 0;
  int passed = 0;

  logic [63:0]   msg_words[$];
  logic [1599:0] resp[$];
  logic [1599:0] obs[$];
  logic [1599:0] expb[$];
  int            n_done;
  int            ready_viol;
  int            xfer_cyc;
  int            perm_cyc;
  bit            timed_out;
  logic          ready_at_done;

  always #5 clk = ~clk;

  keccak_absorb_pad #(.RATE_LANES(R), .DSUFFIX(8'h06)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_nbytes(in_nbytes), .in_ready(in_ready),
    .perm_start(perm_start), .perm_done(perm_done), .state_in(state_in),
    .out_state(out_state), .msg_done(msg_done)
  );

  function automatic logic [1599:0] rand1600();
    logic [1599:0] r;
    for (int i = 0; i < 50; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] lane_of(input logic [1599:0] v, input int k);
    return v[1599-64*k -: 64];
  endfunction

  function automatic int bad_lane(input logic [1599:0] a, input logic [1599:0] b);
    for (int k = 0; k < 25; k++)
      if (lane_of(a, k) !== lane_of(b, k)) return k;
    return 0;
  endfunction

  function automatic int eff_nb(input logic [3:0] n);
`ifdef KECCAK_PARTIAL_LANE_EN
    return (n > 4'd8) ? 8 : int'(n);
`else
    return 8;
`endif
  endfunction

  // Sponge model: message bytes, then suffix byte, zero fill to the rate, 0x80 in the block's last byte.
  task automatic build_expected(input int nwords, input logic [3:0] last_nb);
    logic [7:0]    q[$];
    logic [63:0]   lane;
    logic [1599:0] blk;
    logic [1599:0] s;
    int            n;
    for (int w = 0; w < nwords; w++) begin
      n = (w == nwords - 1) ? eff_nb(last_nb) : 8;
      for (int j = 0; j < n; j++) q.push_back(msg_words[w][8*j +: 8]);
    end
    q.push_back(8'h06);
    while (q.size() % RB != 0) q.push_back(8'h00);
    q[q.size()-1] = q[q.size()-1] | 8'h80;
    expb.delete();
    for (int b = 0; b < q.size() / RB; b++) begin
      blk = '0;
      for (int k = 0; k < R; k++) begin
        for (int j = 0; j < 8; j++) lane[8*j +: 8] = q[b*RB + 8*k + j];
        blk[1599-64*k -: 64] = lane;
      end
      s = (b == 0 || b - 1 >= resp.size()) ? '0 : resp[b-1];
      expb.push_back(s ^ blk);
    end
  endtask

  task automatic fill_words(input int n);
    msg_words.delete();
    for (int i = 0; i < n; i++) msg_words.push_back({$urandom, $urandom});
  endtask

  // Feeds one message and acts as the permutation core; records every block presented on perm_start.
  task automatic drive_message(input int nwords, input logic [3:0] last_nb,
                               input bit gaps, input bit stop_at_perm);
    int idx, cd, cycles;
    bit xfer;
    idx = 0; cd = 0; cycles = 0;
    obs.delete(); resp.delete();
    n_done = 0; timed_out = 0; perm_cyc = -1; xfer_cyc = -1; ready_at_done = 1'bx;
    while (1) begin
      perm_done = 1'b0;
      if (msg_done) begin
        n_done++;
        ready_at_done = in_ready;
        break;
      end
      if (cd > 0) begin
        if (in_ready !== 1'b0) ready_viol++;
        cd--;
        if (cd == 0) begin
          state_in  = rand1600();
          resp.push_back(state_in);
          perm_done = 1'b1;
        end
      end else if (gaps && $urandom_range(0, 3) == 0) begin
        state_in  = rand1600();
        perm_done = 1'b1;
      end
      if (perm_start) begin
        if (in_ready !== 1'b0) ready_viol++;
        obs.push_back(out_state);
        if (perm_cyc < 0) perm_cyc = cycles;
        if (stop_at_perm) break;
        cd = $urandom_range(1, 3);
      end
      in_valid  = (idx < nwords) && (!gaps || $urandom_range(0, 3) != 0);
      in_data   = (idx < nwords) ? msg_words[idx] : {$urandom, $urandom};
      in_last   = (idx == nwords - 1);
      in_nbytes = in_last ? last_nb : 4'($urandom_range(0, 15));
      xfer      = in_valid && in_ready;
      @(posedge clk); #1;
      cycles++;
      if (xfer) begin
        idx++;
        xfer_cyc = cycles;
      end
      if (cycles > 3000) begin
        timed_out = 1;
        break;
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    perm_done = 1'b0;
    if (!stop_at_perm) begin
      repeat (3) begin
        @(posedge clk); #1;
        if (msg_done) n_done++;
        if (perm_start) obs.push_back(out_state);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else passed++;
    total++; if (perm_start !== 1'b0) $display("FAIL reset_perm_start got %b exp 0", perm_start); else passed++;
    total++; if (msg_done !== 1'b0) $display("FAIL reset_msg_done got %b exp 0", msg_done); else passed++;
    total++; if (out_state !== '0) $display("FAIL reset_out_state lane0 got %h exp 0", lane_of(out_state, 0)); else passed++;
    @(negedge clk); reset = 1'b0; #1;
    total++; if (in_ready !== 1'b0) $display("FAIL release_in_ready_early got %b exp 0", in_ready); else passed++;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_min_message();
    logic [1599:0] e;
    fill_words(1);
    drive_message(1, 4'd0, 0, 0);
    build_expected(1, 4'd0);
    total++; if (obs.size() != expb.size()) $display("FAIL min_blocks got %0d exp %0d", obs.size(), expb.size()); else passed++;
    for (int b = 0; b < expb.size(); b++) begin
      e = (b < obs.size()) ? obs[b] : '0;
      total++;
      if (e !== expb[b]) $display("FAIL min_blk%0d lane%0d got %h exp %h", b, bad_lane(e, expb[b]), lane_of(e, bad_lane(e, expb[b])), lane_of(expb[b], bad_lane(e, expb[b])));
      else passed++;
    end
    total++; if (n_done != 1) $display("FAIL min_msg_done got %0d exp 1 (timeout=%0d)", n_done, timed_out); else passed++;
    total++; if (ready_at_done !== 1'b1) $display("FAIL min_ready_after_done got %b exp 1", ready_at_done); else passed++;
`ifdef KECCAK_PARTIAL_LANE_EN
    e = '0;
    e[1599:1536] = 64'h6;
    e[575:512]   = 64'h8000000000000000;
    total++;
    if (obs.size() < 1 || obs[0] !== e) $display("FAIL min_const_block got %0d blocks lane0 %h exp %h", obs.size(), (obs.size() > 0) ? lane_of(obs[0], 0) : 64'h0, 64'h6);
    else passed++;
    total++; if (perm_cyc != xfer_cyc) $display("FAIL min_latency got %0d exp %0d", perm_cyc, xfer_cyc); else passed++;
`endif
  endtask

  task automatic test_partial_lane();
    logic [1599:0] e;
    fill_words(17);
    msg_words[16] = 64'hFFFFFFFFFFFFFFFF;
    drive_message(17, 4'd7, 0, 0);
    build_expected(17, 4'd7);
    total++; if (obs.size() != expb.size()) $display("FAIL partial_blocks got %0d exp %0d", obs.size(), expb.size()); else passed++;
    for (int b = 0; b < expb.size(); b++) begin
      e = (b < obs.size()) ? obs[b] : '0;
      total++;
      if (e !== expb[b]) $display("FAIL partial_blk%0d lane%0d got %h exp %h", b, bad_lane(e, expb[b]), lane_of(e, bad_lane(e, expb[b])), lane_of(expb[b], bad_lane(e, expb[b])));
      else passed++;
    end
    total++; if (n_done != 1) $display("FAIL partial_msg_done got %0d exp 1", n_done); else passed++;
`ifdef KECCAK_PARTIAL_LANE_EN
    e = (obs.size() > 0) ? obs[0] : '0;
    total++; if (lane_of(e, 16) !== 64'h86FFFFFFFFFFFFFF) $display("FAIL partial_lane16 got %h exp 86ffffffffffffff", lane_of(e, 16)); else passed++;
`endif
  endtask

  task automatic test_aligned_full_block();
    logic [1599:0] e;
    logic [1599:0] g;
    fill_words(17);
    drive_message(17, 4'd8, 0, 0);
    build_expected(17, 4'd8);
    total++; if (obs.size() != 2) $display("FAIL aligned_perm_starts got %0d exp 2", obs.size()); else passed++;
    for (int b = 0; b < expb.size(); b++) begin
      g = (b < obs.size()) ? obs[b] : '0;
      total++;
      if (g !== expb[b]) $display("FAIL aligned_blk%0d lane%0d got %h exp %h", b, bad_lane(g, expb[b]), lane_of(g, bad_lane(g, expb[b])), lane_of(expb[b], bad_lane(g, expb[b])));
      else passed++;
    end
    e = '0;
    e[1599:1536] = 64'h6;
    e[575:512]   = 64'h8000000000000000;
    g = (obs.size() > 1 && resp.size() > 0) ? (obs[1] ^ resp[0]) : '1;
    total++; if (g !== e) $display("FAIL aligned_pad_block lane0 got %h exp %h", lane_of(g, 0), lane_of(e, 0)); else passed++;
    total++; if (perm_cyc != xfer_cyc) $display("FAIL aligned_latency got %0d exp %0d", perm_cyc, xfer_cyc); else passed++;
    total++; if (n_done != 1) $display("FAIL aligned_msg_done got %0d exp 1", n_done); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [1599:0] g;
    int            n;
    logic [3:0]    nb;
    ready_viol = 0;
    for (int m = 0; m < 5; m++) begin
      n  = $urandom_range(1, 40);
      nb = 4'($urandom_range(0, 15));
      fill_words(n);
      drive_message(n, nb, 1, 0);
      build_expected(n, nb);
      total++; if (obs.size() != expb.size()) $display("FAIL rand%0d_blocks got %0d exp %0d", m, obs.size(), expb.size()); else passed++;
      for (int b = 0; b < expb.size(); b++) begin
        g = (b < obs.size()) ? obs[b] : '0;
        total++;
        if (g !== expb[b]) $display("FAIL rand%0d_blk%0d lane%0d got %h exp %h", m, b, bad_lane(g, expb[b]), lane_of(g, bad_lane(g, expb[b])), lane_of(expb[b], bad_lane(g, expb[b])));
        else passed++;
      end
      total++; if (n_done != 1) $display("FAIL rand%0d_msg_done got %0d exp 1", m, n_done); else passed++;
    end
    total++; if (ready_viol != 0) $display("FAIL ready_while_busy got %0d exp 0", ready_viol); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    logic [1599:0] g;
    logic [3:0]    nb;
    fill_words(17);
    drive_message(17, 4'd8, 0, 1);
    @(posedge clk); #2;
    reset = 1'b1; #1;
    total++; if (in_ready !== 1'b0) $display("FAIL midwait_in_ready got %b exp 0", in_ready); else passed++;
    total++; if (perm_start !== 1'b0) $display("FAIL midwait_perm_start got %b exp 0", perm_start); else passed++;
    total++; if (msg_done !== 1'b0) $display("FAIL midwait_msg_done got %b exp 0", msg_done); else passed++;
    total++; if (out_state !== '0) $display("FAIL midwait_out_state lane0 got %h exp 0", lane_of(out_state, 0)); else passed++;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    nb = 4'($urandom_range(0, 8));
    fill_words(3);
    drive_message(3, nb, 0, 0);
    build_expected(3, nb);
    total++; if (obs.size() != expb.size()) $display("FAIL midwait_blocks got %0d exp %0d", obs.size(), expb.size()); else passed++;
    for (int b = 0; b < expb.size(); b++) begin
      g = (b < obs.size()) ? obs[b] : '0;
      total++;
      if (g !== expb[b]) $display("FAIL midwait_blk%0d lane%0d got %h exp %h", b, bad_lane(g, expb[b]), lane_of(g, bad_lane(g, expb[b])), lane_of(expb[b], bad_lane(g, expb[b])));
      else passed++;
    end
  endtask

  task automatic test_nbytes_ignored();
    logic [1599:0] g;
    fill_words(2);
    msg_words[1] = 64'h1122334455667788;
    drive_message(2, 4'd3, 0, 0);
    build_expected(2, 4'd3);
    g = (obs.size() > 0) ? obs[0] : '0;
    total++; if (obs.size() != expb.size()) $display("FAIL nbytes_blocks got %0d exp %0d", obs.size(), expb.size()); else passed++;
    total++; if (g !== expb[0]) $display("FAIL nbytes_blk0 lane%0d got %h exp %h", bad_lane(g, expb[0]), lane_of(g, bad_lane(g, expb[0])), lane_of(expb[0], bad_lane(g, expb[0]))); else passed++;
`ifndef KECCAK_PARTIAL_LANE_EN
    total++; if (lane_of(g, 1) !== 64'h1122334455667788) $display("FAIL nbytes_full_word got %h exp 1122334455667788", lane_of(g, 1)); else passed++;
    total++; if (lane_of(g, 2) !== 64'h6) $display("FAIL nbytes_suffix_lane got %h exp 6", lane_of(g, 2)); else passed++;
`endif
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_nbytes = '0;
    perm_done = 1'b0;
    state_in  = '0;
    ready_viol = 0;
    test_reset();
    test_min_message();
    test_partial_lane();
    test_aligned_full_block();
    test_back_to_back();
    test_reset_mid_wait();
    test_nbytes_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
